sad_min_tracker: RTL and testbench
==================================

Name: sad_min_tracker

Overview:
- Consumes the per-candidate SAD values produced by the adder-tree stage (one value per search position).
- Tracks the minimum SAD over a rectangular search window. Reports the winning position (motion vector) and its SAD.
- Sits directly downstream of the SAD adder tree. Feeds the motion-vector writeback logic.

Parameters:
SAD_W, 16, width of incoming SAD and of BestSad
SEARCH_W, 16, candidates per search row (columns)
SEARCH_H, 16, candidate rows in search window
COORD_W, 5, width of row/col outputs; must satisfy 2**COORD_W >= max(SEARCH_W, SEARCH_H)

Ports:
Clk  in  1  rising-edge clock
Reset  in  1  asynchronous, active-low reset
Start  in  1  single-cycle pulse; begins a new search window
SadValid  in  1  SadIn holds a valid candidate SAD this cycle
SadIn  in  SAD_W  SAD of current candidate, raster order (col fastest)
BestSad  out  SAD_W  minimum SAD found so far / final
BestRow  out  COORD_W  row of the minimum
BestCol  out  COORD_W  column of the minimum
Busy  out  1  high while in SEARCH
Done  out  1  one-cycle pulse, search complete
Spurious  out  1  sticky: SadValid seen while not in SEARCH

Behaviour:
- Reset (async, Reset=0) forces:
  - state IDLE
  - BestSad = all ones
  - BestRow = 0, BestCol = 0
  - Busy = 0, Done = 0, Spurious = 0
  - internal row/col counters = 0
- States: IDLE, SEARCH, DONE. All outputs are registered.
- IDLE:
  - Start -> SEARCH.
  - On the Start edge: counters = 0, BestSad = all ones, Spurious = 0, Busy = 1.
- SEARCH, each edge with SadValid=1:
  - The first candidate of the window is always accepted.
  - Later candidates are accepted only if SadIn < BestSad (strict).
  - Ties keep the earlier position.
  - On accept: BestSad = SadIn, BestRow/BestCol = current counters.
  - Counter update: col+1. At col = SEARCH_W-1: col = 0, row+1.
- Last candidate (row = SEARCH_H-1, col = SEARCH_W-1) with SadValid:
  - Compare is applied on that same edge.
  - Next state DONE, Busy = 0, Done = 1 for exactly the following cycle.
  - Latency: Done high in the cycle immediately after the edge that sampled the final SAD.
- SadValid=0 cycles (gaps) stall the counters. There is no timeout.
- DONE lasts one cycle, then -> IDLE. If Start is high while in DONE: -> SEARCH (same as IDLE).
- BestSad/BestRow/BestCol hold their values after DONE until the next Start.
- Start while in SEARCH: restart.
  - Counters and BestSad are reinitialised.
  - A SadValid on the same edge is discarded.
  - No Done is produced for the aborted window.
- Start and SadValid together in IDLE/DONE: start the search, discard the sample, do not set Spurious.
- SadValid in IDLE/DONE without Start: sample ignored, Spurious = 1 (sticky until next Start or reset).
- Reset asserted mid-search: immediate return to reset values, no Done.
- Arithmetic: unsigned SAD compare. No saturation is needed; SadIn is already SAD_W bits.

Optional Feature:
- Macro: SAD_EARLY_EXIT_EN.
- When defined, adds two ports:
  - input Thresh[SAD_W-1:0]
  - output EarlyExit (1 bit, reset 0, cleared on Start)
- In SEARCH, an accepted sample with SadIn <= Thresh:
  - goes to DONE on that edge, with Done pulse and EarlyExit = 1.
  - Further SadValid for that window are ignored and do not set Spurious, until the next Start.
- When undefined: Thresh and EarlyExit ports do not exist, and the full window is always scanned.

Decomposition:
- Shared package sad_pkg:
  - SAD_W default
  - SEARCH_W/SEARCH_H defaults
  - SAD_MAX constant (all ones)
  - state enum type (IDLE, SEARCH, DONE)
- Sub-module sad_cand_counter: raster row/col counter with enable, clear, and last-candidate flag. Parameterised by SEARCH_W/SEARCH_H/COORD_W.

Test Plan:
- Reset low mid-run -> BestSad=16'hFFFF, BestRow=0, BestCol=0, Busy=0, Done=0, Spurious=0 immediately.
- SEARCH_W=4, SEARCH_H=4: Start, 16 back-to-back SADs, all 50 except index 9 = 3 -> BestSad=3, BestRow=2, BestCol=1, Done one cycle after 16th valid, Busy low same cycle.
- Ties, 4x4: value 5 at indices 2 and 7, others 20 -> BestRow=0, BestCol=2. Same stream with SadValid every other cycle -> identical result, Done after 16th valid.
- Restart, 4x4: Start, 6 samples incl. value 1, Start again, 16 samples min 9 at index 15 -> BestSad=9, BestRow=3, BestCol=3, exactly one Done.
- SadValid=1 while IDLE -> Spurious=1, Best* unchanged. Next Start clears Spurious.
- With SAD_EARLY_EXIT_EN, Thresh=10, 4x4: samples 40,30,25,20,15,8 -> Done after 6th sample, EarlyExit=1, BestSad=8, BestRow=1, BestCol=1. Later SadValid does not set Spurious.

Source files
------------

// File: rtl/sad_pkg.sv
// Shared defaults, constants and FSM state type for the SAD minimum tracker.
package sad_pkg;

   localparam int unsigned SAD_W_DEF    = 16;
   localparam int unsigned SEARCH_W_DEF = 16;
   localparam int unsigned SEARCH_H_DEF = 16;
   localparam int unsigned COORD_W_DEF  = 5;

   localparam logic [SAD_W_DEF-1:0] SAD_MAX = '1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2
   } state_t;

endpackage

// File: rtl/sad_cand_counter.sv
// Raster-order (column fastest) candidate position counter with clear, enable
// and a flag for the final position of the search window.
module sad_cand_counter #(
   parameter int unsigned SEARCH_W = 16,
   parameter int unsigned SEARCH_H = 16,
   parameter int unsigned COORD_W  = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               en,
   output logic [COORD_W-1:0] row,
   output logic [COORD_W-1:0] col,
   output logic               last_c
);

   localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(SEARCH_W - 1);
   localparam logic [COORD_W-1:0] ROW_LAST = COORD_W'(SEARCH_H - 1);

   assign last_c = (row == ROW_LAST) && (col == COL_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row <= '0;
         col <= '0;
      end else if (clr) begin
         row <= '0;
         col <= '0;
      end else if (en) begin
         if (col == COL_LAST) begin
            col <= '0;
            row <= (row == ROW_LAST) ? '0 : row + COORD_W'(1);
         end else begin
            col <= col + COORD_W'(1);
         end
      end
   end

endmodule

// File: rtl/sad_min_tracker.sv
// Tracks the minimum SAD over a raster-scanned search window and reports its
// position. Optional threshold early exit is enabled by SAD_EARLY_EXIT_EN.
module sad_min_tracker
   import sad_pkg::*;
#(
   parameter int unsigned SAD_W    = SAD_W_DEF,
   parameter int unsigned SEARCH_W = SEARCH_W_DEF,
   parameter int unsigned SEARCH_H = SEARCH_H_DEF,
   parameter int unsigned COORD_W  = COORD_W_DEF
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               Start,
   input  logic               SadValid,
   input  logic [SAD_W-1:0]   SadIn,
`ifdef SAD_EARLY_EXIT_EN
   input  logic [SAD_W-1:0]   Thresh,
   output logic               EarlyExit,
`endif
   output logic [SAD_W-1:0]   BestSad,
   output logic [COORD_W-1:0] BestRow,
   output logic [COORD_W-1:0] BestCol,
   output logic               Busy,
   output logic               Done,
   output logic               Spurious
);

   localparam logic [SAD_W-1:0] SAD_ONES = '1;

   state_t             state;
   logic [COORD_W-1:0] row;
   logic [COORD_W-1:0] col;
   logic               last_c;
   logic               cnt_en_c;
   logic               first_c;
   logic               accept_c;
   logic               exit_c;
   logic               ignore_c;

   // Counters sit at the origin until the first sample of a window is taken.
   assign first_c  = (row == '0) && (col == '0);
   assign accept_c = first_c || (SadIn < BestSad);
   assign cnt_en_c = (state == SEARCH) && SadValid && !Start;

`ifdef SAD_EARLY_EXIT_EN
   assign exit_c   = accept_c && (SadIn <= Thresh);
   assign ignore_c = EarlyExit;
`else
   assign exit_c   = 1'b0;
   assign ignore_c = 1'b0;
`endif

   sad_cand_counter #(
      .SEARCH_W (SEARCH_W),
      .SEARCH_H (SEARCH_H),
      .COORD_W  (COORD_W)
   ) u_cnt (
      .clk    (Clk),
      .rst_n  (Reset),
      .clr    (Start),
      .en     (cnt_en_c),
      .row    (row),
      .col    (col),
      .last_c (last_c)
   );

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state    <= IDLE;
         BestSad  <= SAD_ONES;
         BestRow  <= '0;
         BestCol  <= '0;
         Busy     <= 1'b0;
         Done     <= 1'b0;
         Spurious <= 1'b0;
`ifdef SAD_EARLY_EXIT_EN
         EarlyExit <= 1'b0;
`endif
      end else begin
         Done <= 1'b0;
         if (Start) begin
            // Start from any state (re)opens a window; a same-edge sample is dropped.
            state    <= SEARCH;
            BestSad  <= SAD_ONES;
            Busy     <= 1'b1;
            Spurious <= 1'b0;
`ifdef SAD_EARLY_EXIT_EN
            EarlyExit <= 1'b0;
`endif
         end else begin
            case (state)
               SEARCH: begin
                  if (SadValid) begin
                     if (accept_c) begin
                        BestSad <= SadIn;
                        BestRow <= row;
                        BestCol <= col;
                     end
                     if (last_c || exit_c) begin
                        state <= DONE;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                     end
`ifdef SAD_EARLY_EXIT_EN
                     if (exit_c) EarlyExit <= 1'b1;
`endif
                  end
               end
               DONE: begin
                  state <= IDLE;
                  if (SadValid && !ignore_c) Spurious <= 1'b1;
               end
               default: begin
                  if (SadValid && !ignore_c) Spurious <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sad_min_tracker.sv
// Scoreboard bench for sad_min_tracker on a 4x4 window; define SAD_EARLY_EXIT_EN
// to also exercise the threshold early exit.
module tb_sad_min_tracker;

   localparam int unsigned SAD_W = 16;
   localparam int unsigned SW    = 4;
   localparam int unsigned SH    = 4;
   localparam int unsigned CW    = 5;
   localparam int unsigned N     = SW * SH;

   logic              Clk = 1'b0;
   logic              Reset;
   logic              Start;
   logic              SadValid;
   logic [SAD_W-1:0]  SadIn;
   logic [SAD_W-1:0]  BestSad;
   logic [CW-1:0]     BestRow;
   logic [CW-1:0]     BestCol;
   logic              Busy;
   logic              Done;
   logic              Spurious;
`ifdef SAD_EARLY_EXIT_EN
   logic [SAD_W-1:0]  Thresh;
   logic              EarlyExit;
`endif

   sad_min_tracker #(
      .SAD_W(SAD_W), .SEARCH_W(SW), .SEARCH_H(SH), .COORD_W(CW)
   ) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .SadValid(SadValid), .SadIn(SadIn),
`ifdef SAD_EARLY_EXIT_EN
      .Thresh(Thresh), .EarlyExit(EarlyExit),
`endif
      .BestSad(BestSad), .BestRow(BestRow), .BestCol(BestCol),
      .Busy(Busy), .Done(Done), .Spurious(Spurious)
   );

   always #5 Clk = ~Clk;

   int total = 0;
   int bad = 0;
   int done_cnt = 0;
   int stim [N];
   logic [SAD_W+2*CW-1:0] exp_q [$];

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Reference: first sample always wins, later ones only on strictly smaller.
   task automatic push_expected(input int n);
      int best;
      int bi;
      best = 0;
      bi = 0;
      for (int i = 0; i < n; i++) begin
         if (i == 0 || stim[i] < best) begin
            best = stim[i];
            bi = i;
         end
      end
      exp_q.push_back({SAD_W'(best), CW'(bi / SW), CW'(bi % SW)});
   endtask

   // Every Done pulse is matched against the oldest expected result.
   always @(negedge Clk) begin
      if (Done === 1'b1) begin
         logic [SAD_W+2*CW-1:0] e;
         done_cnt++;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_done: got Done=1 with no expected result queued");
         end else begin
            e = exp_q.pop_front();
            if ({BestSad, BestRow, BestCol} !== e) begin
               bad++;
               $display("FAIL done_result: got sad=%0d row=%0d col=%0d want sad=%0d row=%0d col=%0d",
                        BestSad, BestRow, BestCol, e[SAD_W+2*CW-1:2*CW], e[2*CW-1:CW], e[CW-1:0]);
            end
         end
      end
   end

   task automatic pulse_start();
      Start = 1'b1;
      tick();
      Start = 1'b0;
      total++;
      if (Busy !== 1'b1 || BestSad !== 16'hFFFF || Done !== 1'b0) begin
         bad++;
         $display("FAIL start_init: got busy=%b sad=%h done=%b want busy=1 sad=ffff done=0",
                  Busy, BestSad, Done);
      end
   endtask

   // Full window from stim[], optional one idle cycle between samples.
   task automatic send_window(input string name, input bit gap);
      bit early;
      int d0;
      early = 1'b0;
      pulse_start();
      push_expected(N);
      d0 = done_cnt;
      for (int i = 0; i < N; i++) begin
         SadValid = 1'b1;
         SadIn = SAD_W'(stim[i]);
         tick();
         if (i < N - 1) begin
            if (Done !== 1'b0 || Busy !== 1'b1) early = 1'b1;
            if (gap) begin
               SadValid = 1'b0;
               tick();
               if (Done !== 1'b0 || Busy !== 1'b1) early = 1'b1;
            end
         end
      end
      SadValid = 1'b0;
      total++;
      if (early) begin
         bad++;
         $display("FAIL %s_early: got Done/Busy change before final sample want none", name);
      end
      total++;
      if (Done !== 1'b1 || Busy !== 1'b0) begin
         bad++;
         $display("FAIL %s_latency: got done=%b busy=%b want done=1 busy=0", name, Done, Busy);
      end
      tick();
      total++;
      if (Done !== 1'b0 || done_cnt != d0 + 1) begin
         bad++;
         $display("FAIL %s_pulse: got done=%b pulses=%0d want done=0 pulses=1",
                  name, Done, done_cnt - d0);
      end
   endtask

   task automatic test_reset();
      Reset = 1'b0;
      Start = 1'b0;
      SadValid = 1'b0;
      SadIn = '0;
`ifdef SAD_EARLY_EXIT_EN
      Thresh = '0;
`endif
      #12;
      total++;
      if (BestSad !== 16'hFFFF || BestRow !== 5'd0 || BestCol !== 5'd0 ||
          Busy !== 1'b0 || Done !== 1'b0 || Spurious !== 1'b0) begin
         bad++;
         $display("FAIL reset_values: got sad=%h row=%0d col=%0d busy=%b done=%b sp=%b want ffff 0 0 0 0 0",
                  BestSad, BestRow, BestCol, Busy, Done, Spurious);
      end
      Reset = 1'b1;
      tick();
   endtask

   task automatic test_basic_min();
      for (int i = 0; i < N; i++) stim[i] = (i == 9) ? 3 : 50;
      send_window("basic", 1'b0);
   endtask

   task automatic test_ties();
      for (int i = 0; i < N; i++) stim[i] = (i == 2 || i == 7) ? 5 : 20;
      send_window("ties", 1'b0);
      send_window("ties_gap", 1'b1);
   endtask

   task automatic test_all_max();
      for (int i = 0; i < N; i++) stim[i] = 16'hFFFF;
      send_window("all_max", 1'b0);
   endtask

   task automatic test_restart();
      int pre [6] = '{30, 20, 1, 25, 40, 12};
      int d0;
      d0 = done_cnt;
      pulse_start();
      for (int i = 0; i < 6; i++) begin
         SadValid = 1'b1;
         SadIn = SAD_W'(pre[i]);
         tick();
      end
      // Restart with a same-edge sample that must be discarded.
      Start = 1'b1;
      SadIn = '0;
      tick();
      Start = 1'b0;
      SadValid = 1'b0;
      total++;
      if (BestSad !== 16'hFFFF || Busy !== 1'b1 || done_cnt != d0) begin
         bad++;
         $display("FAIL restart_reinit: got sad=%h busy=%b pulses=%0d want ffff 1 0",
                  BestSad, Busy, done_cnt - d0);
      end
      for (int i = 0; i < N; i++) stim[i] = (i == N - 1) ? 9 : 30;
      push_expected(N);
      for (int i = 0; i < N; i++) begin
         SadValid = 1'b1;
         SadIn = SAD_W'(stim[i]);
         tick();
      end
      SadValid = 1'b0;
      tick();
      tick();
      total++;
      if (done_cnt != d0 + 1) begin
         bad++;
         $display("FAIL restart_done_count: got %0d want 1", done_cnt - d0);
      end
   endtask

   task automatic test_spurious();
      // Tracker is IDLE holding the restart result 9 @ (3,3).
      SadValid = 1'b1;
      SadIn = 16'd2;
      tick();
      SadValid = 1'b0;
      tick();
      total++;
      if (Spurious !== 1'b1 || BestSad !== 16'd9 || BestRow !== 5'd3 || BestCol !== 5'd3 ||
          Busy !== 1'b0 || Done !== 1'b0) begin
         bad++;
         $display("FAIL spurious_set: got sp=%b sad=%0d row=%0d col=%0d busy=%b done=%b want 1 9 3 3 0 0",
                  Spurious, BestSad, BestRow, BestCol, Busy, Done);
      end
      Start = 1'b1;
      SadValid = 1'b1;
      SadIn = 16'd1;
      tick();
      Start = 1'b0;
      SadValid = 1'b0;
      total++;
      if (Spurious !== 1'b0 || Busy !== 1'b1 || BestSad !== 16'hFFFF) begin
         bad++;
         $display("FAIL spurious_clear: got sp=%b busy=%b sad=%h want 0 1 ffff", Spurious, Busy, BestSad);
      end
   endtask

`ifdef SAD_EARLY_EXIT_EN
   task automatic test_early_exit();
      int seq [6] = '{40, 30, 25, 20, 15, 8};
      bit stray;
      Thresh = 16'd10;
      pulse_start();
      for (int i = 0; i < 6; i++) stim[i] = seq[i];
      push_expected(6);
      for (int i = 0; i < 6; i++) begin
         SadValid = 1'b1;
         SadIn = SAD_W'(seq[i]);
         tick();
      end
      SadValid = 1'b0;
      total++;
      if (Done !== 1'b1 || EarlyExit !== 1'b1 || Busy !== 1'b0) begin
         bad++;
         $display("FAIL early_exit: got done=%b ee=%b busy=%b want 1 1 0", Done, EarlyExit, Busy);
      end
      stray = 1'b0;
      for (int i = 0; i < 3; i++) begin
         SadValid = 1'b1;
         SadIn = 16'd3;
         tick();
         if (i > 0 && Done !== 1'b0) stray = 1'b1;
      end
      SadValid = 1'b0;
      tick();
      total++;
      if (Spurious !== 1'b0 || stray || BestSad !== 16'd8 || EarlyExit !== 1'b1) begin
         bad++;
         $display("FAIL early_exit_after: got sp=%b extra_done=%b sad=%0d ee=%b want 0 0 8 1",
                  Spurious, stray, BestSad, EarlyExit);
      end
      Thresh = '0;
   endtask
`endif

   task automatic test_reset_midrun();
      int d0;
      d0 = done_cnt;
      pulse_start();
      for (int i = 0; i < 5; i++) begin
         SadValid = 1'b1;
         SadIn = 16'd7;
         tick();
      end
      SadValid = 1'b0;
      total++;
      if (BestSad !== 16'd7 || Busy !== 1'b1) begin
         bad++;
         $display("FAIL midrun_progress: got sad=%0d busy=%b want 7 1", BestSad, Busy);
      end
      #2;
      Reset = 1'b0;
      #1;
      total++;
      if (BestSad !== 16'hFFFF || BestRow !== 5'd0 || BestCol !== 5'd0 ||
          Busy !== 1'b0 || Done !== 1'b0 || Spurious !== 1'b0) begin
         bad++;
         $display("FAIL midrun_reset: got sad=%h row=%0d col=%0d busy=%b done=%b sp=%b want ffff 0 0 0 0 0",
                  BestSad, BestRow, BestCol, Busy, Done, Spurious);
      end
      tick();
      Reset = 1'b1;
      tick();
      tick();
      total++;
      if (done_cnt != d0 || Busy !== 1'b0) begin
         bad++;
         $display("FAIL midrun_no_done: got pulses=%0d busy=%b want 0 0", done_cnt - d0, Busy);
      end
   endtask

   initial begin
      test_reset();
      test_basic_min();
      test_ties();
      test_restart();
      test_spurious();
      test_all_max();
`ifdef SAD_EARLY_EXIT_EN
      test_early_exit();
`endif
      test_reset_midrun();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d results outstanding want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
